// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Sequencer for the shared multi-cycle RISC-V datapath (one ULA, one unified
// instruction/data memory port, one register file). Each instruction is
// stepped through fetch, decode, execute, memory and writeback states. Memory
// accesses complete on a mem_ready handshake. A bounded wait counter and an
// opcode check route the machine into a sticky TRAP state, which only reset
// can leave.
//
// Parameters
//   MAX_WAIT   cycles a memory access may wait for mem_ready before trapping
//              (legal range 1..255)
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   Opcode     in   7  IR[6:0], sampled only in DECODE
//   Zero       in   1  ULA zero flag, sampled only in BEQ
//   mem_ready  in   1  memory completes the current access this cycle
//   PCWrite    out  1  load PC
//   PCSrc      out  1  PC source: 0 = ULA result, 1 = ALUOut
//   IorD       out  1  memory address: 0 = PC, 1 = ALUOut
//   IRWrite    out  1  load IR and OldPC
//   MemRead    out  1  memory read request
//   MemWrite   out  1  memory write request
//   MemtoReg   out  1  writeback source: 0 = ALUOut, 1 = MDR
//   RegWrite   out  1  register file write enable
//   ULASrcA    out  2  operand A: 00 = PC, 01 = OldPC, 10 = register A
//   ULASrcB    out  2  operand B: 00 = register B, 01 = 4, 10 = immediate
//   ULAOp      out  2  00 = add, 01 = sub, 10 = R-type funct, 11 = addi
//   trap       out  1  sticky error flag
//   state      out  4  current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [1:0] ULAOp,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXEC_R   = 4'd7,
        EXEC_I   = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // Counter value on the last cycle an access may still wait.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] ULA_ADD    = 2'b00;
    localparam logic [1:0] ULA_SUB    = 2'b01;
    localparam logic [1:0] ULA_FUNCT  = 2'b10;
    localparam logic [1:0] ULA_ADDI   = 2'b11;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;
    logic [6:0] opcode_q;
    logic       timeout;
    logic       mem_wait_state;

    assign state   = state_q;
    assign timeout = (wait_cnt_q == WAIT_LAST);

    // States in which mem_ready is meaningful and the wait counter runs.
    assign mem_wait_state = (state_q == FETCH) || (state_q == MEMREAD) ||
                            (state_q == MEMWRITE);

    // -------------------------------------------------------------------------
    // State, wait counter and latched opcode registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            opcode_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == DECODE) begin
                opcode_q <= Opcode;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Wait counter next value
    // -------------------------------------------------------------------------
    // Clearing on every state change covers entry into FETCH, MEMREAD and
    // MEMWRITE; the counter is only consulted inside those states, so clearing
    // on the other transitions is harmless.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_wait_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // PCWrite/IRWrite in FETCH and PCWrite in BEQ are Mealy outputs taken
    // straight from mem_ready and Zero; everything else depends on state only.
    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ULASrcA  = SRCA_PC;
        ULASrcB  = SRCB_REGB;
        ULAOp    = ULA_ADD;
        trap     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            // Request the instruction and compute PC+4 in parallel.
            FETCH: begin
                MemRead = 1'b1;
                IorD    = 1'b0;
                ULASrcA = SRCA_PC;
                ULASrcB = SRCB_FOUR;
                ULAOp   = ULA_ADD;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = 1'b0;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end

            // OldPC + imm lands in ALUOut so BEQ can use it as the target.
            DECODE: begin
                ULASrcA = SRCA_OLDPC;
                ULASrcB = SRCB_IMM;
                ULAOp   = ULA_ADD;
                case (Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_ADDI:      state_d = EXEC_I;
                    OP_R:         state_d = EXEC_R;
                    OP_BEQ:       state_d = BEQ;
                    default:      state_d = TRAP;
                endcase
            end

            // Effective address; the live Opcode may already have changed,
            // so the load/store choice uses the copy taken in DECODE.
            MEMADR: begin
                ULASrcA = SRCA_REGA;
                ULASrcB = SRCB_IMM;
                ULAOp   = ULA_ADD;
                state_d = (opcode_q == OP_LW) ? MEMREAD : MEMWRITE;
            end

            MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end

            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = FETCH;
            end

            MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end

            EXEC_R: begin
                ULASrcA = SRCA_REGA;
                ULASrcB = SRCB_REGB;
                ULAOp   = ULA_FUNCT;
                state_d = ALUWB;
            end

            EXEC_I: begin
                ULASrcA = SRCA_REGA;
                ULASrcB = SRCB_IMM;
                ULAOp   = ULA_ADDI;
                state_d = ALUWB;
            end

            ALUWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b0;
                state_d  = FETCH;
            end

            // Compare A-B; the target precomputed in DECODE sits in ALUOut.
            BEQ: begin
                ULASrcA = SRCA_REGA;
                ULASrcB = SRCB_REGB;
                ULAOp   = ULA_SUB;
                PCSrc   = 1'b1;
                PCWrite = Zero;
                state_d = FETCH;
            end

            TRAP: begin
                trap    = 1'b1;
                state_d = TRAP;
            end

            // Unused encodings 12..15 fall into TRAP.
            default: begin
                state_d = TRAP;
            end
        endcase
    end

endmodule
